// File: rtl/ram_pkg.sv
// Shared helpers for the SDP buffer RAMs.
//   num_lanes      : number of write-enable lanes in a word
//   ram_merge      : width-parameterised byte-lane merge used by the
//                    write-first forwarding path
//   MAX_RD_LATENCY : deepest supported read pipeline
package ram_pkg;

  localparam int MAX_RD_LATENCY = 4;

  function automatic int num_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Class wrapper so the merge can be sized from the caller's parameters.
  class ram_merge #(parameter int DW = 32, parameter int BW = 8);
    static function logic [DW-1:0] merge_bytes(input logic [DW-1:0]    old_word,
                                               input logic [DW-1:0]    new_word,
                                               input logic [DW/BW-1:0] lane_en);
      logic [DW-1:0] res;
      res = old_word;
      for (int i = 0; i < DW / BW; i++) begin
        if (lane_en[i]) res[i*BW +: BW] = new_word[i*BW +: BW];
      end
      return res;
    endfunction
  endclass

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data delay line: DEPTH register stages of {valid, data}.
// Only the valid bits are reset; data stages are free-running.
// DEPTH=0 is a straight wire.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_valid, i_data  : stage input
//   o_valid, o_data  : delayed by DEPTH cycles
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  if (DEPTH > MAX_RD_LATENCY - 1) begin : g_depth_check
    $fatal(1, "ram_rd_pipe: DEPTH %0d too large", DEPTH);
  end

  if (DEPTH == 0) begin : g_wire
    assign o_valid = i_valid;
    assign o_data  = i_data;
  end else begin : g_stages
    logic [DEPTH-1:0]      r_valid;
    logic [DATA_WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_valid <= '0;
      end else begin
        r_valid[0] <= i_valid;
        for (int i = 1; i < DEPTH; i++) r_valid[i] <= r_valid[i-1];
      end
    end

    always_ff @(posedge i_clk) begin
      r_data[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_data[i] <= r_data[i-1];
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];
  end

endmodule

// File: rtl/ram_sdp_be_pipe.sv
// Simple dual-port RAM with byte write enables and RD_LATENCY-cycle reads.
// Stage 1 is the array read register plus the collision bypass capture;
// the byte merge happens there, then RD_LATENCY-1 plain delay stages.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_rd_en, i_rd_addr           : read request
//   o_rd_data, o_rd_valid        : read result, valid for one cycle per read
//   i_wr_en, i_wr_addr           : write request
//   i_wr_byte_en, i_wr_data      : lane enables and write data
module ram_sdp_be_pipe
  import ram_pkg::*;
#(
  parameter int    DATA_WIDTH  = 32,
  parameter int    BYTE_WIDTH  = 8,
  parameter int    ADDR_WIDTH  = 10,
  parameter int    RD_LATENCY  = 1,
  parameter int    WRITE_FIRST = 1,
  parameter string STYLE       = ""
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_rd_en,
  input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic                             o_rd_valid,
  input  logic                             i_wr_en,
  input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_wr_byte_en,
  input  logic [DATA_WIDTH-1:0]            i_wr_data
);

  localparam int NUM_LANES = num_lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int PIPE_DEPTH = (RD_LATENCY >= 1) ? RD_LATENCY - 1 : 0;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_width_check
    $fatal(1, "ram_sdp_be_pipe: DATA_WIDTH %0d not a multiple of BYTE_WIDTH %0d",
           DATA_WIDTH, BYTE_WIDTH);
  end

  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_latency_check
    $fatal(1, "ram_sdp_be_pipe: RD_LATENCY %0d outside 1..%0d",
           RD_LATENCY, MAX_RD_LATENCY);
  end

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_s1_data;
  logic                  w_out_valid;
  logic [DATA_WIDTH-1:0] w_out_data;

  logic                  r_v1;
  logic                  r_byp;
  logic [DATA_WIDTH-1:0] r_byp_data;
  logic [NUM_LANES-1:0]  r_byp_be;
  logic [DATA_WIDTH-1:0] r_hold;

  // Requests are dropped while in reset so the array stays untouched.
  assign w_rd_acc = i_rd_en && !i_rst;
  assign w_wr_acc = i_wr_en && !i_rst;

  // Array and its read register. Both branches are identical apart from
  // the inference attribute; the attribute-free one keeps tool defaults.
  if (STYLE == "") begin : g_ram
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_word;

    always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (i_wr_byte_en[i])
            r_mem[i_wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      if (w_rd_acc) r_rd_word <= r_mem[i_rd_addr];
    end

    assign w_rd_word = r_rd_word;
  end else begin : g_ram_styled
    (* ram_style = STYLE *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_word;

    always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (i_wr_byte_en[i])
            r_mem[i_wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      if (w_rd_acc) r_rd_word <= r_mem[i_rd_addr];
    end

    assign w_rd_word = r_rd_word;
  end

  // The read register returns pre-write contents on a same-address
  // collision; the bypass flag marks that stage for a byte merge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1  <= 1'b0;
      r_byp <= 1'b0;
    end else begin
      r_v1  <= i_rd_en;
      r_byp <= (WRITE_FIRST != 0) && i_rd_en && i_wr_en && (i_rd_addr == i_wr_addr);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rd_acc) begin
      r_byp_data <= i_wr_data;
      r_byp_be   <= i_wr_byte_en;
    end
  end

  always_comb begin
    w_s1_data = w_rd_word;
    if (r_byp)
      w_s1_data = ram_merge#(DATA_WIDTH, BYTE_WIDTH)::merge_bytes(w_rd_word, r_byp_data, r_byp_be);
  end

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (PIPE_DEPTH)
  ) u_rd_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (r_v1),
    .i_data  (w_s1_data),
    .o_valid (w_out_valid),
    .o_data  (w_out_data)
  );

  // Last valid word is kept so rd_data is stable between reads; the
  // final stage is shown directly in its valid cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst)            r_hold <= '0;
    else if (w_out_valid) r_hold <= w_out_data;
  end

  assign o_rd_valid = w_out_valid;
  assign o_rd_data  = w_out_valid ? w_out_data : r_hold;

endmodule

// File: tb/tb_ram_sdp_be_pipe.sv
module tb_ram_sdp_be_pipe;

  localparam int NDUT = 5;
  localparam int LAT [NDUT] = '{1, 2, 3, 4, 1};
  localparam bit WF  [NDUT] = '{1, 1, 1, 0, 0};

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data  [NDUT];
  logic        rd_valid [NDUT];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  exp_t        sb [NDUT][$];
  logic [31:0] mem_m [1024];
  logic [3:0]  known [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ram_sdp_be_pipe #(
      .DATA_WIDTH (32),
      .BYTE_WIDTH (8),
      .ADDR_WIDTH (10),
      .RD_LATENCY (LAT[g]),
      .WRITE_FIRST(int'(WF[g])),
      .STYLE      ("")
    ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rd_en      (rd_en),
      .i_rd_addr    (rd_addr),
      .o_rd_data    (rd_data[g]),
      .o_rd_valid   (rd_valid[g]),
      .i_wr_en      (wr_en),
      .i_wr_addr    (wr_addr),
      .i_wr_byte_en (wr_be),
      .i_wr_data    (wr_data)
    );
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[i*8 +: 8] = n[i*8 +: 8];
    return o;
  endfunction

  // One cycle of stimulus; expected read results go to the scoreboard.
  task automatic drive(input logic re, input logic [9:0] ra, input logic we,
                       input logic [9:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic rs);
    exp_t e;
    logic [3:0] kn;
    @(negedge clk); #1;
    rst = rs; rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    if (rs) begin
      for (int d = 0; d < NDUT; d++) sb[d].delete();
    end else begin
      if (re) begin
        for (int d = 0; d < NDUT; d++) begin
          e.due  = cyc + LAT[d];
          e.data = mem_m[ra];
          kn     = known[ra];
          if (we && wa == ra && WF[d]) begin
            e.data = merge(e.data, wd, be);
            kn     = kn | be;
          end
          e.chk = (kn == 4'hF);
          sb[d].push_back(e);
        end
      end
      if (we) begin
        mem_m[wa] = merge(mem_m[wa], wd, be);
        known[wa] = known[wa] | be;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // Every cycle: rd_valid must match the scoreboard exactly, data when known.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int d = 0; d < NDUT; d++) begin
        if (sb[d].size() > 0 && sb[d][0].due == cyc) begin
          e = sb[d].pop_front();
          checks++;
          if (rd_valid[d] !== 1'b1) begin
            errors++;
            $display("FAIL rd_valid dut%0d cyc %0d got %b exp 1", d, cyc, rd_valid[d]);
          end
          if (e.chk) begin
            checks++;
            if (rd_data[d] !== e.data) begin
              errors++;
              $display("FAIL rd_data dut%0d cyc %0d got %h exp %h", d, cyc, rd_data[d], e.data);
            end
          end
        end else begin
          checks++;
          if (rd_valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_idle dut%0d cyc %0d got %b exp 0", d, cyc, rd_valid[d]);
          end
        end
      end
    end
  end

  task automatic test_reset();
    drive(1'b1, 10'd1, 1'b0, '0, '0, '0, 1'b1);
    drive(1'b1, 10'd1, 1'b0, '0, '0, '0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rd_valid[d] !== 1'b0 || rd_data[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d got v=%b d=%h exp v=0 d=0", d, rd_valid[d], rd_data[d]);
      end
    end
    mon_en = 1'b1;
    idle(1);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rd_valid[d] !== 1'b0 || rd_data[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_release dut%0d got v=%b d=%h exp v=0 d=0", d, rd_valid[d], rd_data[d]);
      end
    end
  endtask

  task automatic test_basic();
    drive(1'b0, '0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 10'd5, 1'b0, '0, '0, '0, 1'b0);
    idle(6);
  endtask

  task automatic test_partial();
    drive(1'b0, '0, 1'b1, 10'd7, 4'hF, 32'h11223344, 1'b0);
    drive(1'b0, '0, 1'b1, 10'd7, 4'h5, 32'hAABBCCDD, 1'b0);
    drive(1'b1, 10'd7, 1'b0, '0, '0, '0, 1'b0);
    idle(5);
    checks++;
    if (mem_m[7] !== 32'h11BB33DD || rd_data[0] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL partial_write got %h exp %h", rd_data[0], 32'h11BB33DD);
    end
  endtask

  task automatic test_collision();
    drive(1'b0, '0, 1'b1, 10'd9, 4'hF, 32'h01020304, 1'b0);
    drive(1'b1, 10'd9, 1'b1, 10'd9, 4'h3, 32'hFFFFFFFF, 1'b0);
    drive(1'b1, 10'd9, 1'b0, '0, '0, '0, 1'b0);
    idle(6);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 16; i++)
      drive(1'b0, '0, 1'b1, 10'(i), 4'hF, 32'hC0DE0000 + 32'(i * 32'h01010101), 1'b0);
    for (int i = 0; i < 16; i++)
      drive(1'b1, 10'(i), 1'b0, '0, '0, '0, 1'b0);
    idle(6);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rd_data[d] !== mem_m[15]) begin
        errors++;
        $display("FAIL stream_hold dut%0d got %h exp %h", d, rd_data[d], mem_m[15]);
      end
    end
  endtask

  task automatic test_rst_midflight();
    drive(1'b0, '0, 1'b1, 10'd20, 4'hF, 32'h5555AAAA, 1'b0);
    drive(1'b1, 10'd0, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b1, 10'd1, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b1, 10'd2, 1'b1, 10'd20, 4'hF, 32'hFFFF0000, 1'b1);
    drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (rd_data[d] !== 32'h0) begin
        errors++;
        $display("FAIL midflight_data dut%0d got %h exp 0", d, rd_data[d]);
      end
    end
    idle(5);
    checks++;
    if (rd_data[3] !== 32'h0) begin
      errors++;
      $display("FAIL midflight_lat4 got %h exp 0", rd_data[3]);
    end
    drive(1'b1, 10'd20, 1'b0, '0, '0, '0, 1'b0);
    idle(6);
  endtask

  task automatic test_random();
    logic re, we;
    logic [9:0] ra, wa;
    for (int i = 0; i < 300; i++) begin
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      ra = 10'($urandom_range(0, 15));
      wa = ($urandom_range(0, 2) == 0) ? ra : 10'($urandom_range(0, 15));
      drive(re, ra, we, wa, 4'($urandom_range(0, 15)), $urandom, 1'b0);
    end
    idle(6);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      known[i] = 4'h0;
      mem_m[i] = '0;
    end
    test_reset();
    test_basic();
    test_partial();
    test_collision();
    test_stream();
    test_rst_midflight();
    test_random();
    idle(4);
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d pending %0d exp 0", d, sb[d].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
